// File: rtl/rns_mac_accumulator.sv
// Streaming RNS multiply-accumulate engine.
// Four independent 8-bit residue lanes (moduli 251, 241, 239, 233) multiply
// operand pairs, accumulate the products until a beat marked last, then
// present the accumulated residues as one result word with its beat count.
// Pipeline: S1 multiply/reduce register -> S2 accumulate -> output register.

module rns_mac_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_acc,
    output logic [CNT_W-1:0] out_beats,
    output logic             busy
);

    // Lane moduli, lane 0 in bits [7:0] up to lane 3 in bits [31:24].
    localparam int unsigned MOD [4] = '{251, 241, 239, 233};

    logic             s1_valid_reg;
    logic             s1_last_reg;
    logic [31:0]      s1_p_reg;
    logic [31:0]      s1_p_next;
    logic [31:0]      acc_reg;
    logic [31:0]      acc_next;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic [CNT_W-1:0] beat_cnt_inc;
    logic             out_valid_reg;
    logic [31:0]      out_acc_reg;
    logic [CNT_W-1:0] out_beats_reg;

    logic stall;
    logic s1_advance;

    // A finished last beat cannot leave S1 while the output register is
    // still occupied and not being drained; non-last beats are unaffected.
    assign stall      = out_valid_reg & ~out_ready & s1_valid_reg & s1_last_reg;
    assign s1_advance = s1_valid_reg & ~stall;
    assign in_ready   = ~stall;

    // Counter saturates at all-ones; the result count saturates the same way.
    assign beat_cnt_inc = (&beat_cnt_reg) ? beat_cnt_reg : beat_cnt_reg + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0] prod;
            logic [15:0] prod_mod;
            logic [8:0]  sum;
            logic [8:0]  sum_red;

            // Full 16-bit product; residues >= modulus are still reduced here.
            assign prod     = in_a[8*gi +: 8] * in_b[8*gi +: 8];
            assign prod_mod = prod % 16'(MOD[gi]);
            assign s1_p_next[8*gi +: 8] = prod_mod[7:0];

            // Both addends are below the modulus, so one subtract suffices.
            assign sum     = {1'b0, acc_reg[8*gi +: 8]} + {1'b0, s1_p_reg[8*gi +: 8]};
            assign sum_red = (sum >= 9'(MOD[gi])) ? sum - 9'(MOD[gi]) : sum;
            assign acc_next[8*gi +: 8] = sum_red[7:0];
        end
    endgenerate

    // S1: capture reduced per-lane products; hold everything while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_p_reg     <= '0;
        end else if (!stall) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_last_reg <= in_last;
                s1_p_reg    <= s1_p_next;
            end
        end
    end

    // S2: fold products into the accumulator; a last beat restarts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            beat_cnt_reg <= '0;
        end else if (s1_advance) begin
            if (s1_last_reg) begin
                acc_reg      <= '0;
                beat_cnt_reg <= '0;
            end else begin
                acc_reg      <= acc_next;
                beat_cnt_reg <= beat_cnt_inc;
            end
        end
    end

    // Output register: load on a last beat, drop valid when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_acc_reg   <= '0;
            out_beats_reg <= '0;
        end else if (s1_advance && s1_last_reg) begin
            out_valid_reg <= 1'b1;
            out_acc_reg   <= acc_next;
            out_beats_reg <= beat_cnt_inc;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_acc   = out_acc_reg;
    assign out_beats = out_beats_reg;
    assign busy      = s1_valid_reg | (beat_cnt_reg != '0) | out_valid_reg;

endmodule

// File: tb/tb_rns_mac_accumulator.sv
// Directed bench for rns_mac_accumulator with hand-computed RNS results.

module tb_rns_mac_accumulator;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_acc;
    logic [CNT_W-1:0] out_beats;
    logic             busy;

    int checks = 0;
    int errors = 0;

    rns_mac_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_beats (out_beats),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        int n;
        in_a = a;
        in_b = b;
        in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("send_accept", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        $display("beat a=%h b=%h last=%0d", a, b, last);
    endtask

    // Wait (bounded) for a result, check it, then let it drain.
    task automatic expect_result(input string tag, input logic [31:0] acc, input logic [CNT_W-1:0] beats);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_acc"}, out_acc, acc);
        check({tag, "_beats"}, 32'(out_beats), 32'(beats));
        $display("result %s acc=%h beats=%0d", tag, out_acc, out_beats);
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_acc", out_acc, 32'h0);
        check("rst_out_beats", 32'(out_beats), 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        step();

        // Single beat with latency check: valid exactly two cycles after accept
        send(32'h03030303, 32'h05050505, 1'b1);
        check("single_lat0", {31'b0, out_valid}, 32'd0);
        check("single_busy", {31'b0, busy}, 32'd1);
        step();
        check("single_lat1", {31'b0, out_valid}, 32'd1);
        check("single_acc", out_acc, 32'h0F0F0F0F);
        check("single_beats", 32'(out_beats), 32'd1);
        step();
        check("single_drained", {31'b0, out_valid}, 32'd0);

        // Lane wrap: 250*250 per lane
        send(32'hFAFAFAFA, 32'hFAFAFAFA, 1'b1);
        expect_result("wrap", 32'h38795101, 16'd1);

        // Negative: rns(-2) * 3 = rns(-6)
        send({8'd231, 8'd237, 8'd239, 8'd249}, 32'h03030303, 1'b1);
        expect_result("neg", {8'd227, 8'd233, 8'd235, 8'd245}, 16'd1);

        // Dot product 2*3 + 4*5 + 6*7 = 68
        send(32'h02020202, 32'h03030303, 1'b0);
        send(32'h04040404, 32'h05050505, 1'b0);
        send(32'h06060606, 32'h07070707, 1'b1);
        expect_result("dot", 32'h44444444, 16'd3);
        check("dot_idle", {31'b0, busy}, 32'd0);
        send(32'h01010101, 32'h01010101, 1'b1);
        expect_result("fresh", 32'h01010101, 16'd1);

        // Backpressure: two 1-beat streams with the output held
        out_ready = 1'b0;
        send(32'h02020202, 32'h02020202, 1'b1);
        send(32'h03030303, 32'h03030303, 1'b1);
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        check("bp_acc_first", out_acc, 32'h04040404);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        step();
        step();
        check("bp_acc_stable", out_acc, 32'h04040404);
        check("bp_still_stalled", {31'b0, in_ready}, 32'd0);
        check("bp_busy", {31'b0, busy}, 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_second_valid", {31'b0, out_valid}, 32'd1);
        check("bp_second_acc", out_acc, 32'h09090909);
        check("bp_second_beats", 32'(out_beats), 32'd1);
        check("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        $display("result bp second acc=%h beats=%0d", out_acc, out_beats);
        step();
        check("bp_no_dup", {31'b0, out_valid}, 32'd0);

        // Reset mid-stream discards the partial accumulation
        send(32'h05050505, 32'h05050505, 1'b0);
        send(32'h05050505, 32'h05050505, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        send(32'h01010101, 32'h01010101, 1'b1);
        expect_result("after_rst", 32'h01010101, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
